// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit packet scheduler.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StWait,
    StGap
  } sched_state_t;

  localparam logic [7:0] PID_OUT   = 8'h1E;
  localparam logic [7:0] PID_DATA0 = 8'h3C;
  localparam logic [7:0] PID_ACK   = 8'h2D;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning from ptr upwards, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    win,
  output logic [IdxW-1:0] win_idx,
  output logic            any
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    found   = 1'b0;
    cand    = '0;
    win_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IdxW'((32'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    win = '0;
    win[win_idx] = found;
    any = found;
  end

endmodule

// File: rtl/tx_packet_scheduler.sv
// Shares one USB transmit engine among several packet sources with round-robin
// arbitration, a forced inter-packet gap and a per-packet watchdog abort.
module tx_packet_scheduler #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned LEN_W      = 7,
  parameter int unsigned IPG_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [8*NUM_REQ-1:0]     req_pid,
  input  logic [LEN_W*NUM_REQ-1:0] req_len,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       err,
  output logic                     tx_start,
  output logic [7:0]               tx_pid,
  output logic [LEN_W-1:0]         tx_len,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic                     tx_abort
);

  import usb_tx_pkg::*;

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
  localparam int unsigned GapW = $clog2(IPG_CYCLES + 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT - 1);
  localparam logic [WdW-1:0]  WdMax   = WdW'(TIMEOUT);
  localparam logic [GapW-1:0] GapLast = GapW'(IPG_CYCLES - 1);

  sched_state_t state_q, state_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [WdW-1:0]     wd_q, wd_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               tx_start_q, tx_start_d;
  logic               tx_abort_q, tx_abort_d;
  logic [7:0]         pid_q, pid_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic [NUM_REQ-1:0] arb_win;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_any;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .win     (arb_win),
    .win_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    wd_d       = wd_q;
    gap_d      = gap_q;
    gnt_d      = gnt_q;
    pid_d      = pid_q;
    len_d      = len_q;
    done_d     = '0;
    err_d      = '0;
    tx_start_d = 1'b0;
    tx_abort_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req && !tx_busy) state_d = StArb;
      end
      StArb: begin
        if (arb_any) begin
          owner_d    = arb_idx;
          gnt_d      = arb_win;
          pid_d      = req_pid[8*arb_idx +: 8];
          len_d      = req_len[LEN_W*arb_idx +: LEN_W];
          tx_start_d = 1'b1;
          wd_d       = '0;
          state_d    = StWait;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        // Completion takes priority over a coincident watchdog expiry.
        if (tx_done || wd_q == WdLast) begin
          done_d   = tx_done ? gnt_q : '0;
          err_d    = tx_done ? '0 : gnt_q;
          tx_abort_d = !tx_done;
          gnt_d    = '0;
          rr_ptr_d = IdxW'(rr_next(32'(owner_q), NUM_REQ));
          gap_d    = '0;
          state_d  = StGap;
        end else if (wd_q != WdMax) begin
          wd_d = wd_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StIdle;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      wd_q       <= '0;
      gap_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      tx_start_q <= 1'b0;
      tx_abort_q <= 1'b0;
      pid_q      <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tx_start_q <= tx_start_d;
      tx_abort_q <= tx_abort_d;
      pid_q      <= pid_d;
      len_q      <= len_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign tx_start = tx_start_q;
  assign tx_abort = tx_abort_q;
  assign tx_pid   = pid_q;
  assign tx_len   = len_q;

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Directed bench for tx_packet_scheduler: latency, rotation, gap, watchdog, reset, busy hold-off.
module tb_tx_packet_scheduler;
  import usb_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] req_pid;
  logic [20:0] req_len;
  logic [2:0]  gnt, done, err;
  logic        tx_start, tx_busy, tx_done, tx_abort;
  logic [7:0]  tx_pid;
  logic [6:0]  tx_len;

  int checks   = 0;
  int failures = 0;

  tx_packet_scheduler #(
    .NUM_REQ    (3),
    .LEN_W      (7),
    .IPG_CYCLES (4),
    .TIMEOUT    (1024)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_pid  (req_pid),
    .req_len  (req_len),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .tx_start (tx_start),
    .tx_pid   (tx_pid),
    .tx_len   (tx_len),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_abort (tx_abort)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance until tx_start is seen, bounded; n = cycles waited.
  task automatic wait_start(input string tag, output int n);
    n = 0;
    while (tx_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(tx_start), 32'd1);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    int order [4] = '{0, 1, 2, 0};
    logic [7:0] pids [3];
    logic [6:0] lens [3];
    pids[0] = PID_OUT; pids[1] = PID_DATA0; pids[2] = PID_ACK;
    lens[0] = 7'd0;    lens[1] = 7'd64;     lens[2] = 7'd2;
    rst     = 1'b1;
    req     = 3'b000;
    req_pid = {PID_ACK, PID_DATA0, PID_OUT};
    req_len = {7'd2, 7'd64, 7'd0};
    tx_busy = 1'b0;
    tx_done = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_pid", 32'(tx_pid), 0);
    chk("rst_done_err", 32'({done, err, tx_abort}), 0);

    // 1: single source, len 0, 2-cycle launch latency, done after 20 cycles.
    rst = 1'b0;
    tick();
    req = 3'b001;
    tick();
    chk("t1_nostart_yet", 32'(tx_start), 0);
    tick();
    chk("t1_start", 32'(tx_start), 1);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_pid", 32'(tx_pid), 32'h1E);
    chk("t1_len", 32'(tx_len), 0);
    repeat (19) tick();
    chk("t1_gnt_hold", 32'(gnt), 32'h1);
    pulse_done();
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_gnt_clr", 32'(gnt), 0);
    chk("t1_err", 32'(err), 0);
    req = 3'b000;
    tick();
    chk("t1_done_pulse", 32'(done), 0);

    // 2: all three requesting, rotation 0,1,2,0 with enforced gap.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 3'b111;
    for (int p = 0; p < 4; p++) begin
      wait_start("t2_start", n);
      chk("t2_latency", 32'(n), (p == 0) ? 32'd2 : 32'd6);
      chk("t2_gnt", 32'(gnt), 32'(1 << order[p]));
      chk("t2_pid", 32'(tx_pid), 32'(pids[order[p]]));
      chk("t2_len", 32'(tx_len), 32'(lens[order[p]]));
      repeat (3) tick();
      pulse_done();
      chk("t2_done", 32'(done), 32'(1 << order[p]));
    end

    // 3: watchdog abort; rr_ptr now 1 so source 1 wins.
    req = 3'b011;
    wait_start("t3_start", n);
    chk("t3_gnt", 32'(gnt), 32'h2);
    repeat (1023) tick();
    chk("t3_no_err_early", 32'({err, tx_abort}), 0);
    tick();
    chk("t3_err", 32'(err), 32'h2);
    chk("t3_abort", 32'(tx_abort), 1);
    chk("t3_gnt_clr", 32'(gnt), 0);
    tick();
    chk("t3_abort_pulse", 32'(tx_abort), 0);
    wait_start("t3_next_start", n);
    chk("t3_rotate", 32'(gnt), 32'h1);

    // 4: tx_done coincides with the timeout cycle: done wins.
    repeat (1023) tick();
    pulse_done();
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_err", 32'(err), 0);
    chk("t4_abort", 32'(tx_abort), 0);
    req = 3'b000;
    repeat (8) tick();

    // 5: reset mid-packet, then single requester 1 regranted.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 3'b010;
    wait_start("t5_start", n);
    chk("t5_gnt", 32'(gnt), 32'h2);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_gnt", 32'(gnt), 0);
    chk("t5_rst_outs", 32'({done, err, tx_start, tx_abort}), 0);
    chk("t5_rst_pidlen", 32'({tx_pid, tx_len}), 0);
    rst = 1'b0;
    wait_start("t5_restart", n);
    chk("t5_latency", 32'(n), 32'd2);
    chk("t5_regnt", 32'(gnt), 32'h2);
    tick();
    pulse_done();
    chk("t5_done", 32'(done), 32'h2);
    req = 3'b000;
    repeat (8) tick();

    // 6: engine busy holds off arbitration; stray tx_done in IDLE ignored.
    pulse_done();
    chk("t6_stray_done", 32'({done, err}), 0);
    tx_busy = 1'b1;
    req = 3'b001;
    seen = 0;
    repeat (10) begin
      tick();
      if (tx_start === 1'b1) seen = 1;
    end
    chk("t6_no_start", 32'(seen), 0);
    chk("t6_no_gnt", 32'(gnt), 0);
    tx_busy = 1'b0;
    tick();
    chk("t6_start_early", 32'(tx_start), 0);
    tick();
    chk("t6_start", 32'(tx_start), 1);
    chk("t6_gnt", 32'(gnt), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
